// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts a byte on a valid/ready handshake and
// serialises it on tx as start bit, 8 data bits LSB-first, then stop bits.
// Ports:
//   clk       system clock, rising-edge active
//   rst_n     asynchronous active-low reset
//   tx_data   byte to send, sampled only on the accept edge
//   tx_valid  host has a byte on tx_data
//   tx_ready  controller can accept a byte (high only in IDLE)
//   tx        serial line, idle/mark level 1
//   busy      high from accept until frame complete
//   bit_idx   current data-bit index (status)
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] bit_idx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_q, stop_d;
    logic             tx_q, tx_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             stop_last;

    // Baud terminal count ends the current serial bit.
    assign tick      = (cnt_q == CNT_MAX);
    // With two stop bits the second baud period is the last one.
    assign stop_last = (STOP_BITS == 2) ? stop_q : 1'b1;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        stop_d  = stop_q;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    shift_d = tx_data;
                    stop_d  = 1'b0;
                end
            end
            START: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                if (tick) begin
                    if (stop_last) begin
                        state_d = IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[idx_d];
            default: tx_d = 1'b1;
        endcase
        rdy_d  = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = rdy_q;
    assign busy     = busy_q;
    assign bit_idx  = idx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Testbench for uart_tx_ctrl: one instance with one stop bit, one with two,
// checked cycle by cycle against a frame-position reference model.
module tb_uart_tx_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       v1, v2;
    logic       r1, t1, b1, r2, t2, b2;
    logic [2:0] i1, i2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v1),
        .tx_ready(r1), .tx(t1), .busy(b1), .bit_idx(i1)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(v2),
        .tx_ready(r2), .tx(t2), .busy(b2), .bit_idx(i2)
    );

    // Reference: k = cycles since the accept edge; bit slot = k / N.
    function automatic logic ref_tx(input logic [7:0] d, input int k);
        int b;
        b = k / N;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    function automatic logic [2:0] ref_idx(input int k);
        int b;
        b = k / N;
        if (b >= 1 && b <= 8) return 3'(b - 1);
        return 3'd0;
    endfunction

    function automatic logic ref_ready(input int k, input int s);
        return k >= (9 + s) * N;
    endfunction

    task automatic set_valid(input bit sel, input logic val);
        if (sel) v2 = val;
        else     v1 = val;
    endtask

    // Present a byte at a negedge; returns one negedge after the accept edge.
    task automatic start_frame(input logic [7:0] d, input bit sel);
        logic rdy;
        rdy = sel ? r2 : r1;
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_send sel=%0d got=%b exp=1", sel, rdy);
        end
        tx_data = d;
        set_valid(sel, 1'b1);
        @(negedge clk);
    endtask

    // Check tx/ready/busy/bit_idx for frame positions 0..kmax.
    task automatic check_frame(input logic [7:0] d, input bit sel, input bit hold,
                               input logic [7:0] nd, input bit pulse, input int kmax);
        int s;
        logic ot, orr, ob;
        logic [2:0] oi;
        s = sel ? 2 : 1;
        for (int k = 0; k <= kmax; k++) begin
            ot  = sel ? t2 : t1;
            orr = sel ? r2 : r1;
            ob  = sel ? b2 : b1;
            oi  = sel ? i2 : i1;
            checks++;
            if (ot !== ref_tx(d, k)) begin
                errors++;
                $display("FAIL tx sel=%0d byte=%h k=%0d got=%b exp=%b", sel, d, k, ot, ref_tx(d, k));
            end
            checks++;
            if (orr !== ref_ready(k, s)) begin
                errors++;
                $display("FAIL tx_ready sel=%0d byte=%h k=%0d got=%b exp=%b", sel, d, k, orr, ref_ready(k, s));
            end
            checks++;
            if (ob !== !ref_ready(k, s)) begin
                errors++;
                $display("FAIL busy sel=%0d byte=%h k=%0d got=%b exp=%b", sel, d, k, ob, !ref_ready(k, s));
            end
            checks++;
            if (oi !== ref_idx(k)) begin
                errors++;
                $display("FAIL bit_idx sel=%0d byte=%h k=%0d got=%0d exp=%0d", sel, d, k, oi, ref_idx(k));
            end
            if (k == 0 && !hold) set_valid(sel, 1'b0);
            if (pulse && k == 13) begin
                set_valid(sel, 1'b1);
                tx_data = 8'h3C;
            end
            if (pulse && k == 14) set_valid(sel, 1'b0);
            if (k == 20) tx_data = nd;
            if (k < kmax) @(negedge clk);
        end
    endtask

    task automatic check_idle_both(input string tag);
        checks++;
        if ({t1, r1, b1, i1} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL %s dut1 got tx=%b rdy=%b busy=%b idx=%0d exp 1 1 0 0", tag, t1, r1, b1, i1);
        end
        checks++;
        if ({t2, r2, b2, i2} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL %s dut2 got tx=%b rdy=%b busy=%b idx=%0d exp 1 1 0 0", tag, t2, r2, b2, i2);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        v1      = 1'b0;
        v2      = 1'b0;
        tx_data = 8'h00;
        repeat (2) @(negedge clk);
        check_idle_both("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_both("after_release");
    endtask

    task automatic test_frame_a5();
        start_frame(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 8'h11, 1'b0, 10 * N);
    endtask

    task automatic test_stop2();
        start_frame(8'h00, 1'b1);
        check_frame(8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 11 * N);
    endtask

    task automatic test_back_to_back();
        start_frame(8'hFF, 1'b0);
        check_frame(8'hFF, 1'b0, 1'b1, 8'h01, 1'b0, 10 * N);
        @(negedge clk);
        check_frame(8'h01, 1'b0, 1'b0, 8'h77, 1'b0, 10 * N);
    endtask

    task automatic test_busy_ignore();
        start_frame(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 8'h3C, 1'b1, 10 * N);
        @(negedge clk);
        check_idle_both("after_ignored_pulse");
    endtask

    task automatic test_reset_midframe();
        start_frame(8'hA5, 1'b0);
        check_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 12);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({t1, r1, b1, i1} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL midframe_reset got tx=%b rdy=%b busy=%b idx=%0d exp 1 1 0 0", t1, r1, b1, i1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(8'h5A, 1'b0);
        check_frame(8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 10 * N);
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit sel;
        bit pulse;
        for (int n = 0; n < 6; n++) begin
            d     = 8'($urandom);
            sel   = 1'($urandom_range(0, 1));
            pulse = 1'($urandom_range(0, 1));
            start_frame(d, sel);
            check_frame(d, sel, 1'b0, 8'($urandom), pulse, (sel ? 11 : 10) * N);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_stop2();
        test_back_to_back();
        test_busy_ignore();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
